// File: rtl/regfile_wb_sched_if.sv
// Bundles the issue, ALU/LSU writeback, regfile write port and scoreboard
// signals of the writeback scheduler into one connection.
interface regfile_wb_sched_if #(
  parameter int XLEN = 32
);
  logic            iss_valid;
  logic            iss_we;
  logic [4:0]      iss_rd;
  logic [4:0]      iss_rs1;
  logic [4:0]      iss_rs2;
  logic            iss_stall;

  // Valid/ready: a requester holds valid, rd and data stable until ready is
  // high in the same cycle; the request transfers on that cycle's rising edge.
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic [31:0]     busy;
  logic [3:0]      starve;

  modport master (
    output iss_valid, iss_we, iss_rd, iss_rs1, iss_rs2,
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  iss_stall, alu_ready, lsu_ready, rf_we, rf_wa, rf_wd, busy, starve
  );

  modport slave (
    input  iss_valid, iss_we, iss_rd, iss_rs1, iss_rs2,
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output iss_stall, alu_ready, lsu_ready, rf_we, rf_wa, rf_wd, busy, starve
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Shares the single regfile write port between ALU and LSU writeback and
// keeps a per-register busy scoreboard so issue stalls on RAW/WAW hazards.
module regfile_wb_sched #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  regfile_wb_sched_if.slave  bus
);
  logic [3:0]      starve_q, starve_d;
  logic [31:0]     busy_q, busy_d;
  logic            we_q;
  logic [4:0]      wa_q;
  logic [XLEN-1:0] wd_q;

  logic            alu_pri, contended;
  logic            lsu_gnt, alu_gnt, any_gnt;
  logic [4:0]      gnt_rd;
  logic [XLEN-1:0] gnt_data;
  logic            iss_hazard, iss_stall, iss_accept;

  assign alu_pri   = (starve_q >= 4'(STARVE_MAX));
  assign contended = bus.alu_valid & bus.lsu_valid;

  // LSU ready is derived only from the valids and starve, never from ALU ready.
  always_comb begin
    lsu_gnt  = ~reset & bus.lsu_valid & ~(bus.alu_valid & alu_pri);
    alu_gnt  = ~reset & bus.alu_valid & ~lsu_gnt;
    any_gnt  = lsu_gnt | alu_gnt;
    gnt_rd   = lsu_gnt ? bus.lsu_rd   : bus.alu_rd;
    gnt_data = lsu_gnt ? bus.lsu_data : bus.alu_data;
  end

  always_comb begin
    iss_hazard = busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2] |
                 (bus.iss_we & busy_q[bus.iss_rd]);
    iss_stall  = bus.iss_valid & (reset | iss_hazard);
    iss_accept = bus.iss_valid & ~iss_stall;
  end

  always_comb begin
    starve_d = starve_q;
    if (alu_gnt)
      starve_d = 4'd0;
    else if (contended && lsu_gnt)
      starve_d = starve_q + 4'd1;
  end

  // Clear first, then set, so a set on the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (we_q)
      busy_d[wa_q] = 1'b0;
    if (iss_accept && bus.iss_we && (bus.iss_rd != 5'd0))
      busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= 4'd0;
      busy_q   <= 32'd0;
      we_q     <= 1'b0;
      wa_q     <= 5'd0;
      wd_q     <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
      // A grant to x0 consumes the slot but never writes the regfile.
      we_q     <= any_gnt && (gnt_rd != 5'd0);
      if (any_gnt && (gnt_rd != 5'd0)) begin
        wa_q <= gnt_rd;
        wd_q <= gnt_data;
      end
    end
  end

  assign bus.iss_stall = iss_stall;
  assign bus.alu_ready = alu_gnt;
  assign bus.lsu_ready = lsu_gnt;
  assign bus.rf_we     = we_q;
  assign bus.rf_wa     = wa_q;
  assign bus.rf_wd     = wd_q;
  assign bus.busy      = busy_q;
  assign bus.starve    = starve_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: reset, basic write, contention and
// starvation, RAW/WAW hazards, x0 handling and reset in the middle of traffic.
module tb_regfile_wb_sched;
  logic clk;
  logic reset;
  int   checks;
  int   fails;

  regfile_wb_sched_if #(.XLEN(32)) bus ();

  regfile_wb_sched #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Any commit must land on a register the scoreboard marks as in flight.
  always @(negedge clk) begin
    if (!reset && bus.rf_we) begin
      checks++;
      if (!bus.busy[bus.rf_wa]) begin
        fails++;
        $display("FAIL proto_commit_not_busy: rf_wa=%0d busy=%h required busy bit set", bus.rf_wa, bus.busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iss_valid = 1'b0; bus.iss_we = 1'b0;
    bus.iss_rd = 5'd0; bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0;
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
  endtask

  task automatic issue(input logic we, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    bus.iss_valid = 1'b1; bus.iss_we = we;
    bus.iss_rd = rd; bus.iss_rs1 = rs1; bus.iss_rs2 = rs2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.iss_valid = 1'b1; bus.alu_valid = 1'b1; bus.lsu_valid = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (bus.alu_ready !== 1'b0) begin fails++; $display("FAIL reset_alu_ready: got %b required 0", bus.alu_ready); end
    checks++; if (bus.lsu_ready !== 1'b0) begin fails++; $display("FAIL reset_lsu_ready: got %b required 0", bus.lsu_ready); end
    checks++; if (bus.iss_stall !== 1'b1) begin fails++; $display("FAIL reset_iss_stall: got %b required 1", bus.iss_stall); end
    checks++; if (bus.busy !== 32'd0) begin fails++; $display("FAIL reset_busy: got %h required 0", bus.busy); end
    checks++; if (bus.rf_we !== 1'b0 || bus.rf_wa !== 5'd0 || bus.rf_wd !== 32'd0) begin
      fails++; $display("FAIL reset_rf: got we=%b wa=%0d wd=%h required 0/0/0", bus.rf_we, bus.rf_wa, bus.rf_wd); end
    checks++; if (bus.starve !== 4'd0) begin fails++; $display("FAIL reset_starve: got %0d required 0", bus.starve); end
    tick();
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_basic_write();
    issue(1'b1, 5'd5, 5'd0, 5'd0);
    @(negedge clk);
    checks++; if (bus.iss_stall !== 1'b0) begin fails++; $display("FAIL basic_issue_stall: got %b required 0", bus.iss_stall); end
    tick();
    idle_inputs();
    checks++; if (bus.busy !== 32'h0000_0020) begin fails++; $display("FAIL basic_busy_set: got %h required 00000020", bus.busy); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
      fails++; $display("FAIL basic_alu_ready: got alu=%b lsu=%b required 1/0", bus.alu_ready, bus.lsu_ready); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd5 || bus.rf_wd !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL basic_commit: got we=%b wa=%0d wd=%h required 1/5/deadbeef", bus.rf_we, bus.rf_wa, bus.rf_wd); end
    checks++; if (bus.busy !== 32'h0000_0020) begin fails++; $display("FAIL basic_busy_inflight: got %h required 00000020", bus.busy); end
    tick();
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b0 || bus.rf_wd !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL basic_after: got we=%b wd=%h required 0/deadbeef", bus.rf_we, bus.rf_wd); end
    checks++; if (bus.busy !== 32'd0) begin fails++; $display("FAIL basic_busy_clear: got %h required 0", bus.busy); end
    tick();
  endtask

  task automatic test_contention();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1111_1111;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h2222_2222;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (bus.starve !== 4'(i % 5)) begin fails++; $display("FAIL cont_starve[%0d]: got %0d required %0d", i, bus.starve, i % 5); end
      checks++; if (bus.alu_ready !== ((i % 5) == 4) || bus.lsu_ready !== ((i % 5) != 4)) begin
        fails++; $display("FAIL cont_grant[%0d]: got alu=%b lsu=%b required alu=%b", i, bus.alu_ready, bus.lsu_ready, (i % 5) == 4); end
      checks++; if (bus.alu_ready && bus.lsu_ready) begin fails++; $display("FAIL cont_two_readies[%0d]: got both 1 required at most one", i); end
      checks++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL cont_x0_we[%0d]: got %b required 0", i, bus.rf_we); end
      tick();
    end
    tick(); tick();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.starve !== 4'd2 || bus.lsu_ready !== 1'b1) begin
      fails++; $display("FAIL cont_two_wins: got starve=%0d lsu=%b required 2/1", bus.starve, bus.lsu_ready); end
    tick();
    bus.lsu_valid = 1'b0; bus.alu_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.starve !== 4'd2 || bus.alu_ready !== 1'b1) begin
      fails++; $display("FAIL cont_hold: got starve=%0d alu=%b required 2/1", bus.starve, bus.alu_ready); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.starve !== 4'd0) begin fails++; $display("FAIL cont_alu_clears: got %0d required 0", bus.starve); end
    tick();
  endtask

  task automatic test_raw();
    issue(1'b1, 5'd7, 5'd0, 5'd0);
    tick();
    issue(1'b1, 5'd8, 5'd7, 5'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bus.iss_stall !== 1'b1) begin fails++; $display("FAIL raw_stall_wait[%0d]: got %b required 1", i, bus.iss_stall); end
      tick();
    end
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h0000_1234;
    @(negedge clk);
    checks++; if (bus.lsu_ready !== 1'b1 || bus.iss_stall !== 1'b1) begin
      fails++; $display("FAIL raw_lsu_grant: got ready=%b stall=%b required 1/1", bus.lsu_ready, bus.iss_stall); end
    tick();
    bus.lsu_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd7 || bus.iss_stall !== 1'b1) begin
      fails++; $display("FAIL raw_commit_k: got we=%b wa=%0d stall=%b required 1/7/1", bus.rf_we, bus.rf_wa, bus.iss_stall); end
    tick();
    @(negedge clk);
    checks++; if (bus.iss_stall !== 1'b0 || bus.busy !== 32'd0) begin
      fails++; $display("FAIL raw_release: got stall=%b busy=%h required 0/0", bus.iss_stall, bus.busy); end
    tick();
    idle_inputs();
    checks++; if (bus.busy !== 32'h0000_0100) begin fails++; $display("FAIL raw_dep_busy: got %h required 00000100", bus.busy); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_data = 32'hCAFE_0008;
    tick();
    idle_inputs();
    tick();
    @(negedge clk);
    checks++; if (bus.busy !== 32'd0 || bus.rf_wd !== 32'hCAFE_0008) begin
      fails++; $display("FAIL raw_dep_done: got busy=%h wd=%h required 0/cafe0008", bus.busy, bus.rf_wd); end
    tick();
  endtask

  task automatic test_waw_x0();
    issue(1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    issue(1'b1, 5'd3, 5'd1, 5'd2);
    @(negedge clk);
    checks++; if (bus.iss_stall !== 1'b1) begin fails++; $display("FAIL waw_stall: got %b required 1", bus.iss_stall); end
    tick();
    issue(1'b1, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checks++; if (bus.iss_stall !== 1'b0) begin fails++; $display("FAIL x0_issue_stall: got %b required 0", bus.iss_stall); end
    tick();
    idle_inputs();
    checks++; if (bus.busy !== 32'h0000_0008) begin fails++; $display("FAIL x0_issue_busy: got %h required 00000008", bus.busy); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h5555_5555;
    @(negedge clk);
    checks++; if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL x0_alu_ready: got %b required 1", bus.alu_ready); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b0 || bus.busy !== 32'h0000_0008) begin
      fails++; $display("FAIL x0_alu_commit: got we=%b busy=%h required 0/00000008", bus.rf_we, bus.busy); end
    tick();
  endtask

  task automatic test_reset_midflight();
    issue(1'b1, 5'd7, 5'd0, 5'd0);
    tick();
    idle_inputs();
    checks++; if (bus.busy !== 32'h0000_0088) begin fails++; $display("FAIL mid_busy_setup: got %h required 00000088", bus.busy); end
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h7777_7777;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h3333_3333;
    tick();
    reset = 1'b1;
    bus.iss_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd7) begin
      fails++; $display("FAIL mid_pending: got we=%b wa=%0d required 1/7", bus.rf_we, bus.rf_wa); end
    checks++; if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b0 || bus.iss_stall !== 1'b1) begin
      fails++; $display("FAIL mid_during_reset: got alu=%b lsu=%b stall=%b required 0/0/1", bus.alu_ready, bus.lsu_ready, bus.iss_stall); end
    tick();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.busy !== 32'd0 || bus.rf_we !== 1'b0 || bus.starve !== 4'd0) begin
      fails++; $display("FAIL mid_after: got busy=%h we=%b starve=%0d required 0/0/0", bus.busy, bus.rf_we, bus.starve); end
    checks++; if (bus.rf_wa !== 5'd0 || bus.rf_wd !== 32'd0) begin
      fails++; $display("FAIL mid_rf_cleared: got wa=%0d wd=%h required 0/0", bus.rf_wa, bus.rf_wd); end
    tick();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_basic_write();
    test_contention();
    test_raw();
    test_waw_x0();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Register-file writeback scheduler and scoreboard for the core. It shares the single regfile write port (write enable, write address, write data) between the ALU and load/store-unit writeback paths. It also tracks which architectural registers have a write still in flight, so the issue stage stalls on RAW and WAW hazards. It sits between issue, the execution units and `Regfile`.

## Interface
- `XLEN`, 32: data width.
- `STARVE_MAX`, 4: consecutive lost arbitration cycles after which the ALU gets priority (1..15).
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `iss_valid` in 1: issue stage presents an instruction.
- `iss_we` in 1: the instruction writes `iss_rd`.
- `iss_rd`, `iss_rs1`, `iss_rs2` in 5 each: destination and source register indices.
- `iss_stall` out 1: instruction not accepted this cycle.
- `alu_valid` in 1, `alu_rd` in 5, `alu_data` in XLEN: ALU writeback request.
- `alu_ready` out 1: ALU request accepted this cycle.
- `lsu_valid` in 1, `lsu_rd` in 5, `lsu_data` in XLEN: load writeback request.
- `lsu_ready` out 1: LSU request accepted this cycle.
- `rf_we` out 1, `rf_wa` out 5, `rf_wd` out XLEN: regfile write port, registered.
- `busy` out 32: scoreboard, one bit per register; `busy[0]` is always 0.

## Operation
- **Scoreboard**
  - `busy[r]=1` means a write to `r` has been issued and has not yet landed.
  - `iss_stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | (iss_we & busy[iss_rd]))`.
  - Issue is accepted when `iss_valid & !iss_stall`.
  - On accept with `iss_we` and `iss_rd!=0`, `busy[iss_rd]` is set at the next edge.
  - `busy[rf_wa]` is cleared at the edge ending any cycle with `rf_we=1`.
  - Set and clear of the same index on the same edge: set wins. This cannot happen under the WAW stall, but RTL must still implement it.
  - A commit to a non-busy register still writes the regfile and leaves `busy` unchanged. This is a protocol error; the bench flags it.
- **Arbitration**
  - At most one grant per cycle.
  - Default priority is LSU over ALU.
  - Starvation counter `starve` (4 bits) increments each cycle `alu_valid & lsu_valid` with the LSU granted.
  - When `starve >= STARVE_MAX`, the ALU wins the next contended cycle, then `starve` resets to 0.
  - `starve` also resets on any ALU grant, and holds when there is no contention.
  - `lsu_ready = lsu_valid & !(alu_valid & starve>=STARVE_MAX)`.
  - `alu_ready = alu_valid & !lsu_ready`.
- **Handshake**
  - Valid/ready. A requester holds `*_valid`, `*_rd` and `*_data` stable until ready.
  - Ready never depends on the other unit's ready, so there is no combinational loop.
- **Commit**
  - On a grant, the next cycle drives `rf_we=1`, `rf_wa=rd`, `rf_wd=data`.
  - If the granted `rd=0`, the request is accepted and consumes the slot, but `rf_we=0`.
  - With no grant, `rf_we=0`, and `rf_wa`/`rf_wd` hold their previous values.

## Timing
- **Reset values**:
  - `busy=0`, `starve=0`, `rf_we=0`, `rf_wa=0`, `rf_wd=0`.
  - While `reset` is high, `alu_ready=lsu_ready=0` and `iss_stall=iss_valid`.
- **Combinational outputs**: `iss_stall` is combinational from `busy` and the issue inputs. Readies are combinational from the valids and `starve`.
- **Latency**: handshake at cycle N gives `rf_we` at cycle N+1 and `busy` clear at the N+1/N+2 edge. A dependent instruction is therefore accepted no earlier than cycle N+2.
- **Throughput**: one writeback per cycle sustained; back-to-back grants are allowed.
- **Reset mid-operation**: in-flight requests and pending `rf_*` are discarded. The scoreboard clears, so requesters must also reset.

## Test plan
- **Basic write**: reset, then ALU writes `rd=5`, `data=0xDEADBEEF` at cycle 2 → `alu_ready=1` at cycle 2; `rf_we=1`, `rf_wa=5`, `rf_wd=0xDEADBEEF` at cycle 3; `rf_we=0` at cycle 4.
- **Contention and starvation**: both units valid every cycle with `STARVE_MAX=4` → LSU granted 4 cycles, ALU granted on the 5th, pattern repeats; never two readies in one cycle.
- **RAW hazard**:
  - Issue `we`, `rd=7`; the next instruction has `rs1=7` → `iss_stall=1` until the writeback commits.
  - LSU commits `rd=7` with `rf_we` at cycle K → `busy[7]` cleared at the end of K; stall drops at K+1.
- **WAW and x0**:
  - With `busy[3]=1`, issue `we`, `rd=3` → stalled.
  - Issue `we`, `rd=0` → accepted, `busy` unchanged.
  - ALU writeback to `rd=0` → `alu_ready=1`, `rf_we` stays 0.
- **Reset mid-flight**: `busy=0x00000088` and an LSU grant pending; assert `reset` one cycle → `busy=0`, `rf_we=0`, readies 0 during reset, `starve=0` afterwards.
